enet_gmii_tx_framer: RTL and testbench



---
 rtl/enet_gmii_tx_framer.sv | 182 ++++++++++++++++++
 tb/tb_enet_gmii_tx_framer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enet_gmii_tx_framer.sv
// enet_gmii_tx_framer: GMII transmit framer. Prepends preamble/SFD, pads
// short frames, appends the CRC-32 FCS and enforces the inter-frame gap.
// The GMII outputs are registered from the transition being taken, so the
// wire trails the FSM by one cycle.
module enet_gmii_tx_framer #(
    parameter int unsigned IFG_BYTES = 12,
    parameter int unsigned MIN_FRAME = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic [7:0] gmii_txd,
    output logic       underrun,
    output logic       busy
);
    localparam logic [11:0] LP_MIN  = 12'(MIN_FRAME);
    localparam logic [5:0]  LP_IFG  = 6'(IFG_BYTES);
    localparam logic [31:0] LP_POLY = 32'hEDB88320;

    typedef enum logic [3:0] {
        ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_PAD,
        ST_FCS, ST_ABORT, ST_DRAIN, ST_IFG
    } state_t;

    state_t      r_state, w_next;
    logic [2:0]  r_pre_cnt;
    logic [10:0] r_byte_cnt;
    logic [1:0]  r_fcs_idx;
    logic [5:0]  r_ifg_cnt;
    logic [31:0] r_crc;
    logic        r_tx_en, r_tx_er;
    logic [7:0]  r_txd;

    logic        w_tx_en, w_tx_er;
    logic [7:0]  w_txd;
    logic [7:0]  w_crc_din;
    logic [31:0] w_crc_next;
    logic [31:0] w_crc_inv;
    logic [7:0]  w_fcs_byte;
    logic [11:0] w_cnt_inc;
    logic        w_below_min;
    logic [10:0] w_cnt_sat;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] din);
        logic [31:0] c;
        c = crc ^ {24'h000000, din};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ LP_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign w_crc_din   = (r_state == ST_PAD) ? 8'h00 : s_data;
    assign w_crc_next  = crc_step(r_crc, w_crc_din);
    assign w_cnt_inc   = {1'b0, r_byte_cnt} + 12'd1;
    assign w_below_min = (w_cnt_inc < LP_MIN);
    assign w_cnt_sat   = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;
    assign w_crc_inv   = ~r_crc;

    assign gmii_tx_en = r_tx_en;
    assign gmii_tx_er = r_tx_er;
    assign gmii_txd   = r_txd;

    // FCS byte select, least significant byte first
    always_comb begin
        w_fcs_byte = w_crc_inv[7:0];
        case (r_fcs_idx)
            2'd1:    w_fcs_byte = w_crc_inv[15:8];
            2'd2:    w_fcs_byte = w_crc_inv[23:16];
            2'd3:    w_fcs_byte = w_crc_inv[31:24];
            default: w_fcs_byte = w_crc_inv[7:0];
        endcase
    end

    // State register plus counters, CRC and registered GMII outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pre_cnt  <= '0;
            r_byte_cnt <= '0;
            r_fcs_idx  <= '0;
            r_ifg_cnt  <= '0;
            r_crc      <= '1;
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
            r_txd      <= '0;
        end else begin
            r_state <= w_next;
            r_tx_en <= w_tx_en;
            r_tx_er <= w_tx_er;
            r_txd   <= w_txd;
            case (r_state)
                ST_IDLE: begin
                    r_crc      <= '1;
                    r_byte_cnt <= '0;
                    r_pre_cnt  <= '0;
                    r_fcs_idx  <= '0;
                    r_ifg_cnt  <= '0;
                end
                ST_PRE:  r_pre_cnt <= r_pre_cnt + 3'd1;
                ST_DATA: begin
                    if (s_valid) begin
                        r_crc      <= w_crc_next;
                        r_byte_cnt <= w_cnt_sat;
                    end
                end
                ST_PAD: begin
                    r_crc      <= w_crc_next;
                    r_byte_cnt <= w_cnt_sat;
                end
                ST_FCS:  r_fcs_idx <= r_fcs_idx + 2'd1;
                ST_IFG:  r_ifg_cnt <= r_ifg_cnt + 6'd1;
                default: ;
            endcase
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (s_valid) w_next = ST_PRE;
            // IDLE already emits the first 0x55, so PRE covers the other six
            ST_PRE:   if (r_pre_cnt == 3'd5) w_next = ST_SFD;
            ST_SFD:   w_next = ST_DATA;
            ST_DATA: begin
                if (!s_valid)    w_next = ST_ABORT;
                else if (s_last) w_next = w_below_min ? ST_PAD : ST_FCS;
            end
            ST_PAD:   if (!w_below_min) w_next = ST_FCS;
            ST_FCS:   if (r_fcs_idx == 2'd3) w_next = ST_IFG;
            ST_ABORT: w_next = ST_DRAIN;
            ST_DRAIN: if (s_valid && s_last) w_next = ST_IFG;
            // IFG_BYTES+1 cycles here because the wire lags the FSM by one
            ST_IFG:   if (r_ifg_cnt == LP_IFG) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Output decode: next GMII values and combinational status
    always_comb begin
        w_tx_en  = 1'b0;
        w_tx_er  = 1'b0;
        w_txd    = 8'h00;
        s_ready  = (r_state == ST_DATA) || (r_state == ST_DRAIN);
        busy     = (r_state != ST_IDLE);
        underrun = (r_state == ST_ABORT);
        case (r_state)
            ST_IDLE: begin
                if (s_valid) begin
                    w_tx_en = 1'b1;
                    w_txd   = 8'h55;
                end
            end
            ST_PRE: begin
                w_tx_en = 1'b1;
                w_txd   = 8'h55;
            end
            ST_SFD: begin
                w_tx_en = 1'b1;
                w_txd   = 8'hD5;
            end
            ST_DATA: begin
                w_tx_en = 1'b1;
                if (s_valid) w_txd = s_data;
                else         w_tx_er = 1'b1;
            end
            ST_PAD:  w_tx_en = 1'b1;
            ST_FCS: begin
                w_tx_en = 1'b1;
                w_txd   = w_fcs_byte;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_enet_gmii_tx_framer.sv
// tb_enet_gmii_tx_framer: drives directed frames into two framer instances
// (default MIN_FRAME and MIN_FRAME=1) and compares each wire cycle against
// per-instance queues of expected GMII symbols built from the frame rules.
`timescale 1ns/1ps
module tb_enet_gmii_tx_framer;
    localparam int IFG  = 12;
    localparam int MINF = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       rdy1, rdy2, en1, en2, er1, er2, ur1, ur2, busy1, busy2;
    logic [7:0] txd1, txd2;

    always #4 clk = ~clk;

    enet_gmii_tx_framer #(.IFG_BYTES(IFG), .MIN_FRAME(MINF)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy1),
        .s_data(s_data), .s_last(s_last), .gmii_tx_en(en1), .gmii_tx_er(er1),
        .gmii_txd(txd1), .underrun(ur1), .busy(busy1));

    enet_gmii_tx_framer #(.IFG_BYTES(IFG), .MIN_FRAME(1)) dut_min1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy2),
        .s_data(s_data), .s_last(s_last), .gmii_tx_en(en2), .gmii_tx_er(er2),
        .gmii_txd(txd2), .underrun(ur2), .busy(busy2));

    typedef struct packed {
        logic       en;
        logic       er;
        logic [7:0] txd;
        logic       rdy0;   // s_ready must be low on this wire cycle
    } rec_t;

    rec_t       q1[$], q2[$];
    logic [7:0] cap1[$], cap2[$];
    logic [7:0] fdata [0:127];
    int         passed = 0, total = 0;
    bit         chk_on = 0, flush_req = 0;
    int         idle_run = 0, last_gap = 0, ur_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_timeout(input string name);
        total++;
        $display("FAIL %s: timed out waiting, expected completion (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic rec_t mk(input logic en, input logic er, input logic [7:0] txd, input logic rdy0);
        rec_t r;
        r.en = en; r.er = er; r.txd = txd; r.rdy0 = rdy0;
        return r;
    endfunction

    function automatic int qsize(input int id);
        return (id == 0) ? q1.size() : q2.size();
    endfunction

    task automatic push_rec(input int id, input rec_t r);
        if (id == 0) q1.push_back(r);
        else         q2.push_back(r);
    endtask

    // Expected wire stream of one frame: preamble, SFD, data, pad, FCS, gap.
    task automatic model_frame(input int id, input int n, input int minf, input int abort_at);
        logic [31:0] crc;
        logic [7:0]  b;
        int          body;
        crc = 32'hFFFFFFFF;
        if (qsize(id) == 0) push_rec(id, mk(0, 0, 8'h00, 1));   // IDLE sampling cycle
        for (int i = 0; i < 7; i++) push_rec(id, mk(1, 0, 8'h55, 1));
        push_rec(id, mk(1, 0, 8'hD5, 0));
        if (abort_at >= 0) begin
            for (int i = 0; i < abort_at; i++) push_rec(id, mk(1, 0, fdata[i], 0));
            push_rec(id, mk(1, 1, 8'h00, 0));
            return;
        end
        body = (n < minf) ? minf : n;
        for (int i = 0; i < body; i++) begin
            b = (i < n) ? fdata[i] : 8'h00;
            crc = crc_upd(crc, b);
            push_rec(id, mk(1, 0, b, 0));
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) push_rec(id, mk(1, 0, crc[8*i +: 8], 1));
        for (int i = 0; i <= IFG; i++) push_rec(id, mk(0, 0, 8'h00, 1));
    endtask

    function automatic logic [31:0] residue(input int id);
        logic [31:0] c;
        int n;
        c = 32'hFFFFFFFF;
        n = (id == 0) ? cap1.size() : cap2.size();
        for (int i = 8; i < n; i++) c = crc_upd(c, (id == 0) ? cap1[i] : cap2[i]);
        return c;
    endfunction

    task automatic cmp(input int id, input logic en, input logic er, input logic [7:0] txd,
                       input logic ur, input logic rdy, input logic bsy);
        rec_t  r;
        string nm;
        nm = (id == 0) ? "dut" : "dut_min1";
        r = mk(0, 0, 8'h00, 0);
        if (id == 0 && q1.size() > 0) r = q1.pop_front();
        if (id == 1 && q2.size() > 0) r = q2.pop_front();
        check({nm, ".tx_en"}, 32'(en), 32'(r.en));
        check({nm, ".tx_er"}, 32'(er), 32'(r.er));
        check({nm, ".underrun"}, 32'(ur), 32'(r.er));
        if (r.en) begin
            check({nm, ".txd"}, 32'(txd), 32'(r.txd));
            check({nm, ".busy"}, 32'(bsy), 32'd1);
        end
        if (r.rdy0) check({nm, ".s_ready_low"}, 32'(rdy), 32'd0);
        if (en) begin
            if (id == 0) cap1.push_back(txd);
            else         cap2.push_back(txd);
        end
    endtask

    // Per-cycle compare of both instances against their expected streams
    always @(negedge clk) begin
        if (chk_on) begin
            cmp(0, en1, er1, txd1, ur1, rdy1, busy1);
            cmp(1, en2, er2, txd2, ur2, rdy2, busy2);
            if (flush_req) begin
                q1.delete();
                q2.delete();
                flush_req = 0;
            end
            if (ur1) ur_seen++;
            if (!en1) idle_run++;
            else begin
                if (idle_run > 0) last_gap = idle_run;
                idle_run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame with handshake; optional one-cycle gap or reset after a byte.
    task automatic send_frame(input int n, input int gap_at, input int rst_at);
        int guard;
        model_frame(0, n, MINF, gap_at);
        model_frame(1, n, 1, gap_at);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = fdata[i];
            s_last  = (i == n - 1);
            guard   = 0;
            @(negedge clk);
            while (!rdy1 && guard < 200) begin
                guard++;
                @(negedge clk);
            end
            if (!rdy1) begin
                fail_timeout("handshake");
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            tick();
            if (i + 1 == gap_at) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                tick();
            end
            if (i + 1 == rst_at) begin
                rst_n     = 1'b0;
                s_valid   = 1'b0;
                s_last    = 1'b0;
                flush_req = 1;
                @(posedge clk);
                @(negedge clk);
                check("rst_mid.tx_en", 32'(en1), 32'd0);
                check("rst_mid.tx_er", 32'(er1), 32'd0);
                check("rst_mid.txd", 32'(txd1), 32'd0);
                check("rst_mid.busy", 32'(busy1), 32'd0);
                check("rst_mid.s_ready", 32'(rdy1), 32'd0);
                tick();
                rst_n = 1'b1;
                return;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic settle();
        int guard;
        guard = 0;
        while ((q1.size() != 0 || q2.size() != 0) && guard < 1000) begin
            tick();
            guard++;
        end
        if (guard >= 1000) fail_timeout("queue_drain");
        repeat (IFG + 4) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string       s;
        logic [31:0] c;
        int          zeros;

        // Pin the model CRC against the standard check value.
        s = "123456789";
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) c = crc_upd(c, 8'(s[i]));
        check("model_crc_check", ~c, 32'hCBF43926);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.tx_en", 32'(en1), 32'd0);
        check("reset.tx_er", 32'(er1), 32'd0);
        check("reset.txd", 32'(txd1), 32'd0);
        check("reset.s_ready", 32'(rdy1), 32'd0);
        check("reset.underrun", 32'(ur1), 32'd0);
        check("reset.busy", 32'(busy1), 32'd0);
        check("reset.min1_busy", 32'(busy2), 32'd0);
        tick();
        rst_n  = 1'b1;
        chk_on = 1;
        repeat (3) tick();

        // 60-byte frame 0x00..0x3B: exactly minimum, no pad
        for (int i = 0; i < 128; i++) fdata[i] = 8'(i);
        cap1.delete(); cap2.delete();
        send_frame(60, -1, -1);
        settle();
        check("f60.tx_en_cycles", cap1.size(), 32'd72);
        check("f60.residue", residue(0), 32'hDEBB20E3);

        // "123456789": padded on dut, bare FCS on dut_min1
        for (int i = 0; i < 9; i++) fdata[i] = 8'(s[i]);
        cap1.delete(); cap2.delete();
        send_frame(9, -1, -1);
        settle();
        check("f9.min1_len", cap2.size(), 32'd21);
        if (cap2.size() == 21) begin
            check("f9.fcs0", cap2[17], 32'h26);
            check("f9.fcs1", cap2[18], 32'h39);
            check("f9.fcs2", cap2[19], 32'hF4);
            check("f9.fcs3", cap2[20], 32'hCB);
        end
        check("f9.padded_len", cap1.size(), 32'd72);

        // 14-byte frame: 46 pad bytes, FCS over all 60
        for (int i = 0; i < 14; i++) fdata[i] = 8'hA0 + 8'(i);
        cap1.delete(); cap2.delete();
        send_frame(14, -1, -1);
        settle();
        check("f14.len", cap1.size(), 32'd72);
        check("f14.residue", residue(0), 32'hDEBB20E3);
        zeros = 0;
        for (int i = 22; i < 68 && i < cap1.size(); i++) if (cap1[i] == 8'h00) zeros++;
        check("f14.pad_bytes", zeros, 32'd46);

        // Underrun after byte 20 of a 100-byte frame
        for (int i = 0; i < 100; i++) fdata[i] = 8'(i + 1);
        cap1.delete(); cap2.delete();
        ur_seen = 0;
        send_frame(100, 20, -1);
        settle();
        check("underrun.pulses", ur_seen, 32'd1);
        check("underrun.en_cycles", cap1.size(), 32'd29);

        // Two 64-byte frames back to back with s_valid held high
        for (int i = 0; i < 64; i++) fdata[i] = 8'(8'h5A ^ 8'(i * 3));
        cap1.delete(); cap2.delete();
        send_frame(64, -1, -1);
        send_frame(64, -1, -1);
        settle();
        check("b2b.gap", last_gap, 32'd13);
        check("b2b.en_cycles", cap1.size(), 32'd152);

        // Reset at data byte 30, then a fresh frame
        send_frame(64, -1, 30);
        settle();
        for (int i = 0; i < 60; i++) fdata[i] = 8'(8'hC3 + 8'(i * 7));
        cap1.delete(); cap2.delete();
        send_frame(60, -1, -1);
        settle();
        check("post_rst.len", cap1.size(), 32'd72);
        check("post_rst.residue", residue(0), 32'hDEBB20E3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
